// File: rtl/qformat_dequant.sv
// Two-stage converter from signed Q-format fixed point (value = q / 2^FRAC)
// to IEEE-754 binary32. Every legal W fits in the 24-bit significand, so the conversion is exact.
module qformat_dequant #(
  parameter int W    = 8,
  parameter int FRAC = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         busy
);

  logic         s1Valid_q, s1Valid_d;
  logic         s1Sign_q,  s1Sign_d;
  logic         s1Zero_q,  s1Zero_d;
  logic [W-1:0] s1Mag_q,   s1Mag_d;
  logic         outValid_q, outValid_d;
  logic [31:0]  outData_q,  outData_d;

  logic         s1Adv;
  logic         s2Adv;
  logic [4:0]   leadPos;
  logic [23:0]  magExt;
  logic [23:0]  magShift;
  logic [7:0]   expo;
  logic [31:0]  packedWord;

  assign s2Adv     = !outValid_q || out_ready;
  assign s1Adv     = !s1Valid_q || s2Adv;
  assign in_ready  = s1Adv;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign busy      = s1Valid_q | outValid_q;

  // The magnitude is kept W bits unsigned so that -2^(W-1) maps to 2^(W-1).
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Sign_d  = s1Sign_q;
    s1Zero_d  = s1Zero_q;
    s1Mag_d   = s1Mag_q;
    if (s1Adv) begin
      s1Valid_d = in_valid;
      s1Sign_d  = in_data[W-1];
      s1Zero_d  = (in_data == '0);
      s1Mag_d   = in_data[W-1] ? ((~in_data) + W'(1)) : in_data;
    end
  end

  always_comb begin
    leadPos = '0;
    for (int i = 0; i < W; i++) begin
      if (s1Mag_q[i]) leadPos = 5'(i);
    end
  end

  // Shifting the leading one to bit 23 leaves the fraction bits left-aligned in [22:0].
  always_comb begin
    magExt     = 24'(s1Mag_q);
    magShift   = magExt << (5'd23 - leadPos);
    expo       = 8'(int'(leadPos) + 127 - FRAC);
    packedWord = s1Zero_q ? 32'h0 : {s1Sign_q, expo, magShift[22:0]};
  end

  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    if (s2Adv) begin
      outValid_d = s1Valid_q;
      if (s1Valid_q) outData_d = packedWord;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1Valid_q  <= 1'b0;
      s1Sign_q   <= 1'b0;
      s1Zero_q   <= 1'b0;
      s1Mag_q    <= '0;
      outValid_q <= 1'b0;
      outData_q  <= 32'h0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Sign_q   <= s1Sign_d;
      s1Zero_q   <= s1Zero_d;
      s1Mag_q    <= s1Mag_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
    end
  end

endmodule

// File: tb/tb_qformat_dequant.sv
// Scoreboard bench for qformat_dequant (W=8, FRAC=4): expected words are queued
// on acceptance and popped when the block emits a result.
module tb_qformat_dequant;
  localparam int W    = 8;
  localparam int FRAC = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         busy;

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] expQ[$];

  qformat_dequant #(.W(W), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference conversion built from the simulator's double representation.
  function automatic logic [31:0] refModel(input logic [W-1:0] q);
    real r;
    logic [63:0] d;
    if (q == '0) return 32'h0;
    r = real'($signed(q)) / real'(1 << FRAC);
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    nChecks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL reset_state: out_valid=%b out_data=%h busy=%b in_ready=%b, required 0 00000000 0 1",
               out_valid, out_data, busy, in_ready);
    end
    tick();
  endtask

  // Single transfers including the boundary values; result must show exactly two cycles after acceptance.
  task automatic test_single();
    logic [7:0]  vin [7] = '{8'h10, 8'hF0, 8'h01, 8'h7F, 8'h80, 8'h00, 8'hFF};
    logic [31:0] vexp[7] = '{32'h3F800000, 32'hBF800000, 32'h3D800000, 32'h40FE0000,
                             32'hC1000000, 32'h00000000, 32'hBD800000};
    logic [31:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = vin[i];
      @(negedge clk);
      nChecks++;
      if (in_ready !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL single_in_ready[%0d]: got %b, required 1", i, in_ready);
      end
      expQ.push_back(vexp[i]);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      nChecks++;
      if (out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL single_early[%0d]: out_valid=%b one cycle after accept, required 0", i, out_valid);
      end
      tick();
      @(negedge clk);
      e = expQ.pop_front();
      nChecks++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        nFails++;
        $display("[TB] FAIL single_result[%0d] in=%h: out_valid=%b out_data=%h, required 1 %h",
                 i, vin[i], out_valid, out_data, e);
      end
      tick();
      @(negedge clk);
      nChecks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL single_drain[%0d]: busy=%b out_valid=%b, required 0 0", i, busy, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_streaming();
    int nOut = 0;
    int firstCyc = -1;
    int lastCyc = -1;
    int cyc = 0;
    logic [31:0] e;
    out_ready = 1'b1;
    while (cyc < 40 && (cyc < 16 || expQ.size() != 0)) begin
      in_valid = (cyc < 16);
      in_data  = 8'(cyc);
      @(negedge clk);
      if (out_valid) begin
        if (firstCyc < 0) firstCyc = cyc;
        lastCyc = cyc;
        nOut++;
        nChecks++;
        if (expQ.size() == 0) begin
          nFails++;
          $display("[TB] FAIL stream_extra: unexpected out_data=%h", out_data);
        end else begin
          e = expQ.pop_front();
          if (out_data !== e) begin
            nFails++;
            $display("[TB] FAIL stream_data: got %h, required %h", out_data, e);
          end
        end
      end
      if (in_valid) begin
        nChecks++;
        if (in_ready !== 1'b1) begin
          nFails++;
          $display("[TB] FAIL stream_in_ready cyc %0d: got %b, required 1", cyc, in_ready);
        end
        if (in_ready) expQ.push_back(refModel(in_data));
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    nChecks++;
    if (nOut != 16 || lastCyc - firstCyc != 15 || firstCyc != 2) begin
      nFails++;
      $display("[TB] FAIL stream_timing: outputs=%0d first=%0d last=%0d, required 16 2 17",
               nOut, firstCyc, lastCyc);
    end
    expQ.delete();
  endtask

  task automatic test_back_to_back_stall();
    logic [7:0]  vin [3] = '{8'h10, 8'h20, 8'h30};
    logic [31:0] vexp[3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
    int idx = 0;
    int nOut = 0;
    int cyc = 0;
    logic [31:0] e;
    while (cyc < 30 && (idx < 3 || nOut < 3)) begin
      in_valid  = (idx < 3);
      in_data   = (idx < 3) ? vin[idx] : 8'h00;
      out_ready = (cyc >= 7);
      @(negedge clk);
      if (cyc == 4) begin
        nChecks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          nFails++;
          $display("[TB] FAIL bp_full: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
        end
      end
      if (out_valid && !out_ready) begin
        nChecks++;
        if (out_data !== 32'h3F800000) begin
          nFails++;
          $display("[TB] FAIL bp_hold cyc %0d: got %h, required 3f800000", cyc, out_data);
        end
      end
      if (out_valid && out_ready) begin
        nOut++;
        nChecks++;
        if (expQ.size() == 0) begin
          nFails++;
          $display("[TB] FAIL bp_extra: unexpected out_data=%h", out_data);
        end else begin
          e = expQ.pop_front();
          if (out_data !== e) begin
            nFails++;
            $display("[TB] FAIL bp_data: got %h, required %h", out_data, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(vexp[idx]);
        idx++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    nChecks++;
    if (nOut != 3 || expQ.size() != 0 || out_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL bp_count: outputs=%0d pending=%0d out_valid=%b, required 3 0 0",
               nOut, expQ.size(), out_valid);
    end
    expQ.delete();
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc = 0;
    logic held = 1'b0;
    logic [31:0] heldData = 32'h0;
    logic [31:0] e;
    while (cyc < 20000 && (sent < 1000 || expQ.size() != 0)) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (held) begin
        nChecks++;
        if (out_valid !== 1'b1 || out_data !== heldData) begin
          nFails++;
          $display("[TB] FAIL rand_stable cyc %0d: out_valid=%b out_data=%h, required 1 %h",
                   cyc, out_valid, out_data, heldData);
        end
      end
      if (out_valid && out_ready) begin
        nChecks++;
        if (expQ.size() == 0) begin
          nFails++;
          $display("[TB] FAIL rand_extra: unexpected out_data=%h", out_data);
        end else begin
          e = expQ.pop_front();
          if (out_data !== e) begin
            nFails++;
            $display("[TB] FAIL rand_data: got %h, required %h", out_data, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(refModel(in_data));
        sent++;
      end
      held     = out_valid && !out_ready;
      heldData = out_data;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    nChecks++;
    if (sent != 1000 || expQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL rand_timeout: sent=%0d pending=%0d, required 1000 0", sent, expQ.size());
    end
    expQ.delete();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h10;
    tick();
    in_data = 8'h20;
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    nChecks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL midreset_state: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
               out_valid, busy, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      nChecks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL midreset_stale[%0d]: out_valid=%b busy=%b out_data=%h, required 0 0",
                 i, out_valid, busy, out_data);
      end
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_back_to_back_stall();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/qformat_dequant.md
Name: qformat_dequant

Overview:
- Pipelined converter from signed Q-format fixed point (micromind datapath values) to IEEE-754 single-precision float.
- Reverse direction of the float-to-Q quantization path.
- Sits at the output of the inference datapath, feeding host-visible result registers and the debug trace.
- Conversion is exact, with no rounding, because W never exceeds 24 bits of significand.

Parameters:
- W, 8, total width of the input Q value including sign; legal range 2..24.
- FRAC, 4, number of fractional bits; legal range 0..W-1. Represented value = q / 2^FRAC.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low: reset==0 sampled at a rising clk edge resets the block.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  W  signed two's-complement Q value.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  32  IEEE-754 binary32 result.
- busy  output  1  at least one conversion in flight (either stage valid).

Behaviour:
- Reset values: out_valid=0, out_data=32'h0, busy=0. Internal stage-valid bits are 0. in_ready=1 in the first cycle after reset is released.
- Handshake: a transfer occurs on a cycle where valid&&ready. in_ready must not depend combinationally on in_valid. out_data is held stable while out_valid=1 and out_ready=0.
- Pipeline has two registered stages.
  - S1: capture the sign and the absolute magnitude. The magnitude is W bits unsigned, so -2^(W-1) is handled without overflow. Also capture the zero flag.
  - S2: leading-one detect, normalize, pack into out_data and out_valid.
- Latency: result appears 2 cycles after acceptance. With out_ready held at 1, throughput is one conversion per cycle.
- Stall rule: each stage advances when its successor is empty or is being drained.
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - No bubbles are inserted, and no data is dropped or duplicated under any out_ready pattern.
- Arithmetic:
  - sign = in_data[W-1].
  - m = |in_data|.
  - p = index of the most significant 1 in m (0..W-1).
  - exponent = 127 + p - FRAC. This never under- or overflows for the legal parameter ranges.
  - mantissa[22:0] = bits of m below p, left-aligned to bit 22, zero-filled.
  - out_data = {sign, exponent[7:0], mantissa}.
- Zero: in_data==0 gives out_data=32'h00000000 (+0.0). A negative zero is never produced.
- Most negative input is exact: W=8, FRAC=4, 8'h80 gives -8.0 = 32'hC1000000.
- busy = s1_valid | out_valid.
- Reset mid-operation: all in-flight conversions are discarded. Stage-valid bits and out_valid are cleared at that edge, and no partial result is ever presented.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.

Test Plan (W=8, FRAC=4):
- Single transfers, one at a time with out_ready=1 -> each result appears exactly 2 cycles after acceptance:
  - 8'h10 -> 32'h3F800000
  - 8'hF0 -> 32'hBF800000
  - 8'h01 -> 32'h3D800000
  - 8'h7F -> 32'h40FE0000
- Boundary values -> 8'h80 gives 32'hC1000000; 8'h00 gives 32'h00000000; 8'hFF gives 32'hBD800000.
- Streaming: 16 back-to-back inputs 8'h00..8'h0F with out_ready=1 -> in_ready stays 1 throughout, 16 in-order outputs on consecutive cycles, each matching the bench reference model.
- Back-pressure: stream 8'h10, 8'h20, 8'h30 while out_ready=0 -> out_valid=1 holding 32'h3F800000 stable, and in_ready=0 once both stages are full. Then raise out_ready -> outputs are 32'h3F800000, 32'h40000000, 32'h40400000 in order, with no loss or duplication.
- Random stress: 1000 random in_data values with random in_valid/out_ready -> every output matches the reference model in order, and out_data is stable whenever out_valid=1 and out_ready=0.
- Reset mid-flight: accept 8'h10 and 8'h20, then drive reset=0 for one edge while out_ready=0 -> next cycle out_valid=0, busy=0, in_ready=1, and no stale result ever emerges.
